rnd_seq_ctrl: RTL and testbench
===============================

Name: rnd_seq_ctrl

Overview:
- Sequencer for the random vector generator (rnd_vec_gen): the only driver of its init/save/restore/next strobes.
- Accepts burst commands: FRESH runs N new vectors; REPLAY re-emits the last FRESH burst bit-exactly.
- Provides per-vector valid, pause/backpressure, busy/done status and a vector index.
- Replaces the open-coded init/next state machine at the top level.

Parameters:
- LEN_W, 16, width of burst length and vector index
- GEN_LAT, 1, clocks from gen_next to the new vector appearing on the generator output (1..4)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command request
- cmd_replay  in  1  0 = FRESH burst, 1 = REPLAY from checkpoint; sampled with cmd_valid
- cmd_len  in  LEN_W  number of vectors; sampled with cmd_valid
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- pause  in  1  hold: no gen_next is issued while high
- gen_init  out  1  one-cycle strobe to generator init
- gen_save  out  1  one-cycle strobe to generator save (checkpoint)
- gen_restore  out  1  one-cycle strobe to generator restore
- gen_next  out  1  advance strobe, at most one per cycle
- vec_valid  out  1  generator output holds a vector of the current burst
- vec_idx  out  LEN_W  index (0-based) of the vector qualified by vec_valid
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst completion
- err  out  1  one-cycle pulse when a REPLAY is rejected

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs are 0, vec_idx = 0, has_ckpt = 0, state = INIT.
- Strobe exclusivity: gen_init, gen_save, gen_restore and gen_next are mutually exclusive in every cycle; the checker must flag any overlap.
- State INIT (first cycle after rst falls):
  - gen_init = 1 for exactly one cycle.
  - Next state is IDLE.
- State IDLE:
  - cmd_ready = 1.
  - On accept with cmd_replay = 0: latch len and go to SAVE.
  - On accept with cmd_replay = 1 and has_ckpt = 1: latch len and go to RESTORE.
  - On accept with cmd_replay = 1 and has_ckpt = 0: pulse err next cycle, stay in IDLE, leave all strobes low.
- State SAVE:
  - gen_save = 1 for one cycle.
  - Set has_ckpt = 1 and store len into saved_len.
  - Go to RUN.
- State RESTORE:
  - gen_restore = 1 for one cycle.
  - Go to RUN.
  - REPLAY uses the newly latched len. If it exceeds saved_len, vectors beyond saved_len are still produced; they are new but deterministic.
- State RUN:
  - busy = 1. Internal counters issued and emitted start at 0.
  - gen_next = !pause && (issued < len). Issued increments on each gen_next.
  - Each gen_next is delayed through a GEN_LAT-deep shift register. Its output drives vec_valid, and vec_idx = emitted, which then increments.
  - When emitted == len: go to DONE.
- State DONE:
  - done = 1 for one cycle; busy drops in the same cycle.
  - Go to IDLE.
- cmd_ready is 0 in every state except IDLE. A cmd_valid held high during a burst is accepted in the first IDLE cycle.
- cmd_len = 0:
  - SAVE or RESTORE strobe is still issued.
  - RUN exits immediately and no gen_next is issued.
  - done pulses 2 cycles after accept.
- Pause:
  - Pause only suppresses new gen_next.
  - Vectors already in the latency pipe still emerge with vec_valid.
  - Pause has no effect outside RUN.
- Widths:
  - Counters are LEN_W bits; the maximum burst is 2^LEN_W − 1.
  - No wrap-around is possible because issued ≤ len.
- Reset mid-burst:
  - Aborts the burst; all outputs return to reset values and the latency pipe is cleared.
  - has_ckpt is cleared.
  - INIT re-runs, so gen_init pulses in the first cycle after rst falls.
- Throughput: with pause low, a burst of N takes 2 + N + GEN_LAT cycles from accept to done (accept → SAVE/RESTORE → RUN).

Decomposition:
- Shared package (rnd_pkg):
  - State encoding localparams INIT, IDLE, SAVE, RESTORE, RUN, DONE (3-bit).
  - Command encodings CMD_FRESH = 0, CMD_REPLAY = 1.
- Sub-module: rnd_lat_pipe, a GEN_LAT-deep valid shift register with synchronous clear, which produces vec_valid.
- The rest of the logic stays in the FSM.

Test Plan:
- Reset release → gen_init high exactly 1 cycle, cmd_ready high from cycle 2, no other strobe.
- FRESH len=5 with GEN_LAT=1 →
  - gen_save 1 cycle after accept.
  - gen_next on 5 consecutive cycles.
  - vec_valid on 5 cycles with vec_idx 0..4.
  - done pulse 8 cycles after accept.
- FRESH len=4, capture vectors, then REPLAY len=4 →
  - gen_restore pulse, no gen_save.
  - The 4 captured vectors are identical and in the same order.
- REPLAY right after reset → err pulse, no strobes, cmd_ready stays 1; a following FRESH len=0 → gen_save pulse, no gen_next, done 2 cycles after accept.
- FRESH len=6 with pause held high for cycles 3–5 of RUN →
  - No gen_next during the pause.
  - Exactly 6 vec_valid with contiguous indices.
  - done delayed by 3 cycles.
- rst asserted after the 2nd vec_valid of a len=10 burst →
  - Outputs cleared next cycle, gen_init pulses after release.
  - A following REPLAY gives err.

Source files
------------

// File: rtl/rnd_pkg.sv
// rnd_pkg: shared state and command encodings for the random vector sequencer
package rnd_pkg;
  typedef enum logic [2:0] {
    INIT    = 3'd0,
    IDLE    = 3'd1,
    SAVE    = 3'd2,
    RESTORE = 3'd3,
    RUN     = 3'd4,
    DONE    = 3'd5
  } state_t;
  localparam logic CMD_FRESH  = 1'b0;
  localparam logic CMD_REPLAY = 1'b1;
endpackage

// File: rtl/rnd_lat_pipe.sv
// rnd_lat_pipe: LAT-deep valid shift register with synchronous clear
module rnd_lat_pipe #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic clr_i,
  input  logic in_i,
  output logic out_o
);
  logic [LAT-1:0] sr_q;
  always_ff @(posedge clk) begin
    if (clr_i) sr_q <= '0;
    else sr_q <= LAT'({sr_q, in_i});
  end
  assign out_o = sr_q[LAT-1];
endmodule

// File: rtl/rnd_seq_ctrl.sv
// rnd_seq_ctrl: burst sequencer driving the init/save/restore/next strobes of rnd_vec_gen
module rnd_seq_ctrl import rnd_pkg::*; #(
  parameter int LEN_W   = 16,
  parameter int GEN_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic             cmd_replay,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_ready,
  input  logic             pause,
  output logic             gen_init,
  output logic             gen_save,
  output logic             gen_restore,
  output logic             gen_next,
  output logic             vec_valid,
  output logic [LEN_W-1:0] vec_idx,
  output logic             busy,
  output logic             done,
  output logic             err
);
  state_t           state_q;
  logic             has_ckpt_q, err_q;
  logic [LEN_W-1:0] len_q, issued_q, emitted_q, emitted_d;
  // gen_init is gated by rst so the INIT strobe only shows once reset is released
  assign gen_init    = state_q == INIT && !rst;
  assign cmd_ready   = state_q == IDLE;
  assign gen_save    = state_q == SAVE;
  assign gen_restore = state_q == RESTORE;
  assign gen_next    = state_q == RUN && !pause && issued_q < len_q;
  assign busy        = state_q inside {SAVE, RESTORE, RUN};
  assign done        = state_q == DONE;
  assign err         = err_q;
  assign vec_idx     = emitted_q;
  assign emitted_d   = emitted_q + LEN_W'(vec_valid);
  rnd_lat_pipe #(.LAT(GEN_LAT)) u_pipe (
    .clk   (clk),
    .clr_i (rst),
    .in_i  (gen_next),
    .out_o (vec_valid)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      has_ckpt_q <= 1'b0;
      err_q      <= 1'b0;
      len_q      <= '0;
      issued_q   <= '0;
      emitted_q  <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        INIT: state_q <= IDLE;
        IDLE: if (cmd_valid) begin
          if (cmd_replay == CMD_FRESH || has_ckpt_q) begin
            len_q     <= cmd_len;
            issued_q  <= '0;
            emitted_q <= '0;
            state_q   <= cmd_replay == CMD_REPLAY ? RESTORE : SAVE;
          end else err_q <= 1'b1;
        end
        SAVE: begin
          has_ckpt_q <= 1'b1;
          state_q    <= len_q == '0 ? DONE : RUN;
        end
        RESTORE: state_q <= len_q == '0 ? DONE : RUN;
        RUN: begin
          issued_q  <= issued_q + LEN_W'(gen_next);
          emitted_q <= emitted_d;
          if (emitted_d == len_q) state_q <= DONE;
        end
        DONE: state_q <= IDLE;
        default: state_q <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_rnd_seq_ctrl.sv
// tb_rnd_seq_ctrl: directed bench with a cycle-timing model of the sequencer and a toy generator
module tb_rnd_seq_ctrl;
  localparam int LEN_W = 16;
  localparam int GEN_LAT = 1;
  logic clk = 1'b0, rst, cmd_valid, cmd_replay, pause;
  logic [LEN_W-1:0] cmd_len, vec_idx;
  logic cmd_ready, gen_init, gen_save, gen_restore, gen_next, vec_valid, busy, done, err;
  rnd_seq_ctrl #(.LEN_W(LEN_W), .GEN_LAT(GEN_LAT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_replay(cmd_replay), .cmd_len(cmd_len),
    .cmd_ready(cmd_ready), .pause(pause), .gen_init(gen_init), .gen_save(gen_save),
    .gen_restore(gen_restore), .gen_next(gen_next), .vec_valid(vec_valid), .vec_idx(vec_idx),
    .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_err = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // toy generator: the vectors a replay must reproduce
  logic [15:0] g = 16'h0, g_ck = 16'h0;
  always @(posedge clk) begin
    if (gen_init) g <= 16'hACE1;
    else if (gen_restore) g <= g_ck;
    else if (gen_next) g <= {g[14:0], g[15] ^ g[13] ^ g[12] ^ g[10]};
    if (gen_save) g_ck <= g;
  end
  int n_init = 0, n_save = 0, n_rest = 0, n_next = 0, n_valid = 0, n_errp = 0;
  int init_cyc = -1, rdy_cyc = -1, save_cyc = -1, done_cyc = -1;
  bit done_seen = 0, started = 0;
  logic [15:0] caps[$];
  // model: timing measured in cycles since command acceptance
  bit m_init = 1, m_burst = 0, m_rep = 0, m_ck = 0, m_errp = 0;
  int m_t = 0, m_len = 0, m_iss = 0, m_emit = 0;
  int q[$];
  bit e_init, e_ready, e_err, e_save, e_rest, e_done, e_busy, e_next, e_valid;
  always @(negedge clk) begin
    if (!started) started = rst;
    else begin
      e_init  = m_init && !rst;
      e_ready = !m_init && !m_burst;
      e_err   = !m_init && m_errp;
      e_save  = m_burst && m_t == 1 && !m_rep;
      e_rest  = m_burst && m_t == 1 && m_rep;
      e_done  = m_burst && m_t >= 2 && m_emit == m_len;
      e_busy  = m_burst && m_t >= 1 && !e_done;
      e_next  = m_burst && m_t >= 2 && !pause && m_iss < m_len;
      e_valid = m_burst && q.size() > 0 && q[0] + GEN_LAT == m_t;
      chk("gen_init", gen_init, e_init);
      chk("cmd_ready", cmd_ready, e_ready);
      chk("err", err, e_err);
      chk("gen_save", gen_save, e_save);
      chk("gen_restore", gen_restore, e_rest);
      chk("done", done, e_done);
      chk("busy", busy, e_busy);
      chk("gen_next", gen_next, e_next);
      chk("vec_valid", vec_valid, e_valid);
      if (e_valid) chk("vec_idx", vec_idx, m_emit);
      if (m_init) chk("vec_idx_rst", vec_idx, 0);
      chk("strobe_excl", 32'(gen_init) + 32'(gen_save) + 32'(gen_restore) + 32'(gen_next) <= 1, 1);
      if (rst) begin
        m_init = 1; m_burst = 0; m_ck = 0; m_errp = 0; q.delete();
      end else if (m_init) m_init = 0;
      else begin
        m_errp = 0;
        if (m_burst) begin
          if (e_next) begin q.push_back(m_t); m_iss++; end
          if (e_valid) begin void'(q.pop_front()); m_emit++; end
          m_t++;
          if (e_done) m_burst = 0;
        end else if (cmd_valid) begin
          if (!cmd_replay || m_ck) begin
            m_burst = 1; m_t = 1; m_len = int'(cmd_len); m_rep = cmd_replay;
            m_iss = 0; m_emit = 0; q.delete();
            if (!cmd_replay) m_ck = 1;
          end else m_errp = 1;
        end
      end
    end
    if (gen_init) begin n_init++; init_cyc = cyc; end
    if (cmd_ready && rdy_cyc < 0) rdy_cyc = cyc;
    if (gen_save) begin n_save++; save_cyc = cyc; end
    if (gen_restore) n_rest++;
    if (gen_next) n_next++;
    if (vec_valid) begin n_valid++; caps.push_back(g); end
    if (err) n_errp++;
    if (done) begin done_seen = 1; done_cyc = cyc; end
  end
  task automatic clr_ev();
    n_init = 0; n_save = 0; n_rest = 0; n_next = 0; n_valid = 0; n_errp = 0;
    done_seen = 0; caps.delete();
  endtask
  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic issue(bit rep, int len, output int acc);
    cmd_valid = 1; cmd_replay = rep; cmd_len = LEN_W'(len); acc = cyc;
    step(1);
    cmd_valid = 0;
  endtask
  task automatic run_cmd(bit rep, int len, int p_lo, int p_hi, output int acc, output int dlat);
    clr_ev();
    issue(rep, len, acc);
    for (int k = 0; k < 300 && !done_seen; k++) begin
      pause = (cyc - acc) >= p_lo && (cyc - acc) <= p_hi;
      step(1);
    end
    pause = 0;
    chk("done_in_time", done_seen, 1);
    dlat = done_cyc - acc;
  endtask
  task automatic do_reset(int n);
    rst = 1;
    step(n);
    rst = 0; rdy_cyc = -1;
  endtask
  logic [15:0] ref_v[$];
  int acc, dl;
  initial begin
    rst = 1; cmd_valid = 0; cmd_replay = 0; cmd_len = '0; pause = 0;
    step(3);
    clr_ev();
    rst = 0; rdy_cyc = -1;
    step(3);
    chk("init_pulses", n_init, 1);
    chk("ready_after_init", rdy_cyc - init_cyc, 1);
    chk("no_save_at_init", n_save + n_next + n_rest, 0);
    run_cmd(0, 5, 100, 0, acc, dl);
    chk("save_lat", save_cyc - acc, 1);
    chk("fresh5_next", n_next, 5);
    chk("fresh5_valid", n_valid, 5);
    chk("fresh5_done_lat", dl, 8);
    run_cmd(0, 4, 100, 0, acc, dl);
    ref_v = caps;
    chk("fresh4_caps", ref_v.size(), 4);
    run_cmd(1, 4, 100, 0, acc, dl);
    chk("replay_restore", n_rest, 1);
    chk("replay_no_save", n_save, 0);
    chk("replay_caps", caps.size(), 4);
    for (int i = 0; i < 4 && i < caps.size() && i < ref_v.size(); i++) chk("replay_vec", caps[i], ref_v[i]);
    chk("replay_done_lat", dl, 7);
    do_reset(2);
    step(3);
    clr_ev();
    issue(1, 3, acc);
    step(3);
    chk("nockpt_err", n_errp, 1);
    chk("nockpt_strobes", n_save + n_rest + n_next, 0);
    run_cmd(0, 0, 100, 0, acc, dl);
    chk("len0_save", n_save, 1);
    chk("len0_next", n_next, 0);
    chk("len0_done_lat", dl, 2);
    run_cmd(0, 6, 4, 6, acc, dl);
    chk("pause_next", n_next, 6);
    chk("pause_valid", n_valid, 6);
    chk("pause_done_lat", dl, 12);
    clr_ev();
    issue(0, 10, acc);
    for (int k = 0; k < 50 && n_valid < 2; k++) step(1);
    chk("mid_two_valid", n_valid, 2);
    clr_ev();
    rst = 1;
    step(1);
    rst = 0;
    chk("mid_busy_clr", busy, 0);
    chk("mid_valid_clr", vec_valid, 0);
    chk("mid_idx_clr", vec_idx, 0);
    step(3);
    chk("mid_reinit", n_init, 1);
    issue(1, 4, acc);
    step(3);
    chk("mid_replay_err", n_errp, 1);
    chk("mid_replay_no_restore", n_rest, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
